// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: one-cycle-latency memory, small in-order queue, redirect flush.
// Optional macro IFETCH_MISALIGN_CHECK_EN halts fetch on a misaligned redirect target.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        misalign_fault
);

  localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic             inflight_q, inflight_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_mem_q [DEPTH];
  logic [31:0]      pc_mem_q    [DEPTH];

  logic             enq, deq, halt, redir_bad;
  logic [31:0]      redir_pc;
  logic [CNT_W:0]   occ_after;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef IFETCH_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  assign redir_pc       = redirect_pc;
  assign redir_bad      = (redirect_pc[1:0] != 2'b00);
  assign halt           = fault_q;
  assign misalign_fault = fault_q;

  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = redir_bad;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_pc[1:0];
  assign redir_pc        = {redirect_pc[31:2], 2'b00};
  assign redir_bad       = 1'b0;
  assign halt            = 1'b0;
  assign misalign_fault  = 1'b0;
`endif

  assign id_valid = (count_q != '0);
  assign id_instr = id_valid ? instr_mem_q[head_q] : 32'h0;
  assign id_pc    = id_valid ? pc_mem_q[head_q]    : 32'h0;
  assign mem_addr = fetch_pc_q;

  // A response in flight always lands next cycle, so it is counted as already occupying a slot.
  always_comb begin
    enq       = inflight_q && !redirect_valid;
    deq       = id_valid && id_ready && !redirect_valid;
    occ_after = {1'b0, count_q} + (CNT_W + 1)'(inflight_q) - (CNT_W + 1)'(deq);
    mem_req   = !reset && !redirect_valid && !halt && (occ_after < (CNT_W + 1)'(DEPTH));
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = mem_req;
    inflight_pc_d = fetch_pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    if (redirect_valid) begin
      // Flush; the response arriving this cycle is dropped by not enqueuing it.
      fetch_pc_d = redir_pc;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (mem_req) fetch_pc_d = fetch_pc_q + 32'd4;
      if (enq)     tail_d     = ptr_inc(tail_q);
      if (deq)     head_d     = ptr_inc(head_q);
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem_q[i] <= 32'h0;
        pc_mem_q[i]    <= 32'h0;
      end
    end else if (enq) begin
      instr_mem_q[tail_q] <= mem_rdata;
      pc_mem_q[tail_q]    <= inflight_pc_q;
    end
  end

endmodule
